nabp_filtered_ram_ring_control: RTL and testbench

- Parametrised successor to the two-buffer filtered RAM swap controller.
- Manages a ring of NUM_BUFS filtered RAM slots instead of a fixed ping-pong pair.
- Host/filter fills slots in ring order; up to two processing channels (old/new) work on consecutive angles at once.
- Sits between the host angle source plus FIR output and the processing swappables; drives slot kicks and routes slot data.

---
 rtl/nabp_fram_pkg.sv | 44 ++++
 rtl/nabp_fram_slot_tracker.sv | 93 +++++++++
 rtl/nabp_filtered_ram_ring_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_nabp_filtered_ram_ring_control.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_fram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nabp_fram_pkg
// Purpose  : Shared types and helpers for the filtered-RAM ring controller.
//            Holds the slot status and controller state encodings, the
//            slot-index / counter width helpers and the ring-increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial ring version
// ============================================================================
package nabp_fram_pkg;

  // Life cycle of one filtered RAM slot.
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL    = 2'd2,
    SLOT_WORK    = 2'd3
  } slot_status_t;

  // Host-side fill sequencer states.
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } fsm_state_t;

  // Width of a slot index (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Next slot index in ring order.
  function automatic int ring_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : nabp_fram_pkg
`default_nettype wire

// File: rtl/nabp_fram_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module   : nabp_fram_slot_tracker
// Purpose  : Per-slot status and angle tag registers plus the free/full/work
//            occupancy counters of the filtered RAM ring.
// Ports    : clk, reset_n      - clock, synchronous active-low reset
//            fill_start [N]    - one-hot: slot starts filling, tag captured
//            fill_tag          - angle tag stored on fill_start
//            fill_done [N]     - one-hot: slot has finished filling
//            grant [N]         - one-hot: full slot handed to processing
//            rel [N]           - one-hot: working slot released
//            status[N], tag[N] - per-slot status and tag
//            free_cnt, full_cnt, work_cnt - occupancy counters
// Revision : 1.0 - initial ring version
// ============================================================================
module nabp_fram_slot_tracker
  import nabp_fram_pkg::*;
#(
  parameter  int NUM_BUFS = 3,
  parameter  int ANGLE_W  = 8,
  localparam int CNT_W    = cnt_w(NUM_BUFS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BUFS-1:0] fill_start,
  input  logic [ANGLE_W-1:0]  fill_tag,
  input  logic [NUM_BUFS-1:0] fill_done,
  input  logic [NUM_BUFS-1:0] grant,
  input  logic [NUM_BUFS-1:0] rel,
  output slot_status_t        status [NUM_BUFS],
  output logic [ANGLE_W-1:0]  tag    [NUM_BUFS],
  output logic [CNT_W-1:0]    free_cnt,
  output logic [CNT_W-1:0]    full_cnt,
  output logic [CNT_W-1:0]    work_cnt
);

  logic [CNT_W-1:0] r_free_cnt;
  logic [CNT_W-1:0] r_full_cnt;
  logic [CNT_W-1:0] r_work_cnt;
  logic             w_any_done;
  logic             w_any_grant;
  logic             w_any_rel;

  for (genvar i = 0; i < NUM_BUFS; i++) begin : g_slot
    slot_status_t       r_status;
    logic [ANGLE_W-1:0] r_tag;

    // A slot only ever receives one strobe per cycle: the controller aims
    // fill, grant and release at slots in distinct states.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_status <= SLOT_FREE;
        r_tag    <= '0;
      end else if (fill_start[i]) begin
        r_status <= SLOT_FILLING;
        r_tag    <= fill_tag;
      end else if (fill_done[i]) begin
        r_status <= SLOT_FULL;
      end else if (grant[i]) begin
        r_status <= SLOT_WORK;
      end else if (rel[i]) begin
        r_status <= SLOT_FREE;
      end
    end

    assign status[i] = r_status;
    assign tag[i]    = r_tag;
  end

  assign w_any_done  = |fill_done;
  assign w_any_grant = |grant;
  assign w_any_rel   = |rel;

  // A FILLING slot still counts as free: it holds no usable data until its
  // done pulse, so the three counters always sum to NUM_BUFS.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_free_cnt <= CNT_W'(NUM_BUFS);
      r_full_cnt <= '0;
      r_work_cnt <= '0;
    end else begin
      r_free_cnt <= r_free_cnt + CNT_W'(w_any_rel)   - CNT_W'(w_any_done);
      r_full_cnt <= r_full_cnt + CNT_W'(w_any_done)  - CNT_W'(w_any_grant);
      r_work_cnt <= r_work_cnt + CNT_W'(w_any_grant) - CNT_W'(w_any_rel);
    end
  end

  assign free_cnt = r_free_cnt;
  assign full_cnt = r_full_cnt;
  assign work_cnt = r_work_cnt;

endmodule : nabp_fram_slot_tracker
`default_nettype wire

// File: rtl/nabp_filtered_ram_ring_control.sv
`default_nettype none
// ============================================================================
// Module   : nabp_filtered_ram_ring_control
// Purpose  : Ring controller for NUM_BUFS filtered RAM slots. Requests angles
//            from the host, kicks slot fills in ring order, hands full slots
//            to up to two processing channels (old/new) and routes slot data.
// Ports    : clk, reset_n                    - clock, sync active-low reset
//            hs_angle, hs_has_next_angle,
//            hs_next_angle_ack, hs_next_angle - host angle handshake
//            hs_s_val, buf_hs_s_val          - fill address mux
//            buf_fill_kick, buf_fill_done    - per-slot fill control
//            buf_pr0_val, buf_pr1_val,
//            pr0_val, pr1_val                - processing data mux
//            pr_next_angle(_ack),
//            pr_prev_angle_release(_ack),
//            pr_angle, pr_has_next_angle     - processing handshake
//            stat_stall_cycles,
//            stat_underrun_cycles            - statistics counters
// Options  : NABP_FRAM_RING_STATS_EN - builds the saturating statistics
//            counters; otherwise the stat ports read 0.
// Revision : 1.0 - initial ring version
// ============================================================================
module nabp_filtered_ram_ring_control
  import nabp_fram_pkg::*;
#(
  parameter int NUM_BUFS = 3,
  parameter int ANGLE_W  = 8,
  parameter int S_W      = 9,
  parameter int DATA_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ANGLE_W-1:0]         hs_angle,
  input  logic                       hs_has_next_angle,
  input  logic                       hs_next_angle_ack,
  output logic                       hs_next_angle,
  output logic [S_W-1:0]             hs_s_val,
  input  logic [NUM_BUFS*S_W-1:0]    buf_hs_s_val,
  output logic [NUM_BUFS-1:0]        buf_fill_kick,
  input  logic [NUM_BUFS-1:0]        buf_fill_done,
  input  logic [NUM_BUFS*DATA_W-1:0] buf_pr0_val,
  input  logic [NUM_BUFS*DATA_W-1:0] buf_pr1_val,
  input  logic                       pr_next_angle,
  output logic                       pr_next_angle_ack,
  input  logic                       pr_prev_angle_release,
  output logic                       pr_prev_angle_release_ack,
  output logic [ANGLE_W-1:0]         pr_angle,
  output logic                       pr_has_next_angle,
  output logic [DATA_W-1:0]          pr0_val,
  output logic [DATA_W-1:0]          pr1_val,
  output logic [15:0]                stat_stall_cycles,
  output logic [15:0]                stat_underrun_cycles
);

  localparam int IDX_W = idx_w(NUM_BUFS);
  localparam int CNT_W = cnt_w(NUM_BUFS);
  localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_ALL = CNT_W'(NUM_BUFS);

  fsm_state_t          r_state;
  fsm_state_t          w_state_nxt;
  logic [IDX_W-1:0]    r_wr_ptr;
  logic [IDX_W-1:0]    r_full_head;
  logic [IDX_W-1:0]    r_old_ptr;
  logic [IDX_W-1:0]    r_new_ptr;
  logic [NUM_BUFS-1:0] r_fill_kick;

  logic [NUM_BUFS-1:0] w_fill_start;
  logic [NUM_BUFS-1:0] w_fill_done;
  logic [NUM_BUFS-1:0] w_grant;
  logic [NUM_BUFS-1:0] w_rel;
  logic [NUM_BUFS-1:0] w_wr_onehot;
  logic [NUM_BUFS-1:0] w_head_onehot;
  logic [NUM_BUFS-1:0] w_old_onehot;
  logic [IDX_W-1:0]    w_wr_ptr_inc;
  logic [IDX_W-1:0]    w_head_inc;
  logic                w_grant_ack;
  logic                w_rel_ack;
  logic                w_any_filling;
  logic [CNT_W-1:0]    w_free_after;

  slot_status_t        w_status [NUM_BUFS];
  logic [ANGLE_W-1:0]  w_tag    [NUM_BUFS];
  logic [CNT_W-1:0]    w_free_cnt;
  logic [CNT_W-1:0]    w_full_cnt;
  logic [CNT_W-1:0]    w_work_cnt;

  logic [S_W-1:0]      w_hs_s [NUM_BUFS];
  logic [DATA_W-1:0]   w_pr0  [NUM_BUFS];
  logic [DATA_W-1:0]   w_pr1  [NUM_BUFS];

  for (genvar i = 0; i < NUM_BUFS; i++) begin : g_unpack
    assign w_hs_s[i] = buf_hs_s_val[i*S_W +: S_W];
    assign w_pr0[i]  = buf_pr0_val[i*DATA_W +: DATA_W];
    assign w_pr1[i]  = buf_pr1_val[i*DATA_W +: DATA_W];
  end

  nabp_fram_slot_tracker #(
    .NUM_BUFS (NUM_BUFS),
    .ANGLE_W  (ANGLE_W)
  ) u_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .fill_start (w_fill_start),
    .fill_tag   (hs_angle),
    .fill_done  (w_fill_done),
    .grant      (w_grant),
    .rel        (w_rel),
    .status     (w_status),
    .tag        (w_tag),
    .free_cnt   (w_free_cnt),
    .full_cnt   (w_full_cnt),
    .work_cnt   (w_work_cnt)
  );

  assign w_wr_onehot   = NUM_BUFS'(1) << r_wr_ptr;
  assign w_head_onehot = NUM_BUFS'(1) << r_full_head;
  assign w_old_onehot  = NUM_BUFS'(1) << r_old_ptr;
  assign w_wr_ptr_inc  = IDX_W'(ring_inc(int'(r_wr_ptr), NUM_BUFS));
  assign w_head_inc    = IDX_W'(ring_inc(int'(r_full_head), NUM_BUFS));

  // Processing handshake: at most two slots may be in WORK at once.
  assign w_grant_ack = reset_n && pr_next_angle && (w_full_cnt != '0) && (w_work_cnt < C_TWO);
  assign w_rel_ack   = reset_n && pr_prev_angle_release && (w_work_cnt != '0);
  assign w_grant     = w_grant_ack ? w_head_onehot : '0;
  assign w_rel       = w_rel_ack ? w_old_onehot : '0;

  // Free slots after the current fill completes, including a same-cycle release.
  assign w_free_after = w_free_cnt - CNT_W'(1) + CNT_W'(w_rel_ack);

  always_comb begin
    w_any_filling = 1'b0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (w_status[i] == SLOT_FILLING) w_any_filling = 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_REQ;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fill_start = '0;
    w_fill_done  = '0;
    case (r_state)
      ST_REQ: begin
        if (hs_next_angle_ack) begin
          if (hs_has_next_angle) begin
            w_fill_start = w_wr_onehot;
            w_state_nxt  = ST_FILL;
          end else begin
            w_state_nxt  = ST_DRAIN;
          end
        end
      end
      ST_FILL: begin
        // Only the slot being filled may complete; other done bits are noise.
        if (buf_fill_done[r_wr_ptr]) begin
          w_fill_done = w_wr_onehot;
          w_state_nxt = (w_free_after != '0) ? ST_REQ : ST_STALL;
        end
      end
      ST_STALL: begin
        if (w_rel_ack) w_state_nxt = ST_REQ;
      end
      ST_DRAIN: begin
        // Whole ring empty: the next projection set may start.
        if (w_free_cnt == C_ALL) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  // ----------------------------------------------------------- pointers ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_full_head <= '0;
      r_old_ptr   <= '0;
      r_new_ptr   <= '0;
      r_fill_kick <= '0;
    end else begin
      r_fill_kick <= w_fill_start;
      if (|w_fill_done) r_wr_ptr <= w_wr_ptr_inc;
      if (w_grant_ack) begin
        r_new_ptr   <= r_full_head;
        r_full_head <= w_head_inc;
      end
      // WORK slots are contiguous in ring order behind full_head, so after a
      // release the next-oldest one is new_ptr (two working) or the slot at
      // full_head, which is exactly the one being granted if a grant coincides.
      if (w_rel_ack) begin
        r_old_ptr <= (w_work_cnt == C_TWO) ? r_new_ptr : r_full_head;
      end else if (w_grant_ack && (w_work_cnt == '0)) begin
        r_old_ptr <= r_full_head;
      end
    end
  end

  // ------------------------------------------------------------ outputs ----
  assign hs_next_angle             = reset_n && (r_state == ST_REQ);
  assign hs_s_val                  = w_hs_s[r_wr_ptr];
  assign buf_fill_kick             = r_fill_kick;
  assign pr_next_angle_ack         = w_grant_ack;
  assign pr_prev_angle_release_ack = w_rel_ack;
  assign pr_angle                  = (reset_n && (w_full_cnt != '0)) ? w_tag[r_full_head] : '0;
  assign pr_has_next_angle         = !((r_state == ST_DRAIN) && (w_full_cnt == '0) && !w_any_filling);
  assign pr0_val                   = w_pr0[r_old_ptr];
  assign pr1_val                   = w_pr1[r_new_ptr];

  // --------------------------------------------------------- statistics ----
`ifdef NABP_FRAM_RING_STATS_EN
  logic [15:0] r_stat_stall;
  logic [15:0] r_stat_underrun;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stat_stall    <= '0;
      r_stat_underrun <= '0;
    end else begin
      if ((r_state == ST_STALL) && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
      if (pr_next_angle && (w_full_cnt == '0) && (r_state != ST_DRAIN) &&
          (r_stat_underrun != 16'hFFFF)) begin
        r_stat_underrun <= r_stat_underrun + 16'd1;
      end
    end
  end

  assign stat_stall_cycles    = r_stat_stall;
  assign stat_underrun_cycles = r_stat_underrun;
`else
  assign stat_stall_cycles    = '0;
  assign stat_underrun_cycles = '0;
`endif

endmodule : nabp_filtered_ram_ring_control
`default_nettype wire

// File: tb/tb_nabp_filtered_ram_ring_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_nabp_filtered_ram_ring_control
// Purpose  : Directed self-checking bench for the filtered RAM ring
//            controller (NUM_BUFS=3). Inputs change 1 time unit after the
//            rising edge; outputs are checked 2 units later.
// Options  : NABP_FRAM_RING_STATS_EN selects the expected statistics values.
// Revision : 1.0 - initial ring version
// ============================================================================
module tb_nabp_filtered_ram_ring_control;

  localparam int NB = 3;
  localparam int AW = 8;
  localparam int SW = 9;
  localparam int DW = 16;

`ifdef NABP_FRAM_RING_STATS_EN
  localparam int EXP_UNDERRUN = 10;
  localparam int EXP_STALL    = 2;
`else
  localparam int EXP_UNDERRUN = 0;
  localparam int EXP_STALL    = 0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [AW-1:0]  hs_angle = '0;
  logic           hs_has_next_angle = 1'b0;
  logic           hs_next_angle_ack = 1'b0;
  logic           hs_next_angle;
  logic [SW-1:0]  hs_s_val;
  logic [NB*SW-1:0] buf_hs_s_val = {9'd12, 9'd11, 9'd10};
  logic [NB-1:0]  buf_fill_kick;
  logic [NB-1:0]  buf_fill_done = '0;
  logic [NB*DW-1:0] buf_pr0_val = {16'h1002, 16'h1001, 16'h1000};
  logic [NB*DW-1:0] buf_pr1_val = {16'h2002, 16'h2001, 16'h2000};
  logic           pr_next_angle = 1'b0;
  logic           pr_next_angle_ack;
  logic           pr_prev_angle_release = 1'b0;
  logic           pr_prev_angle_release_ack;
  logic [AW-1:0]  pr_angle;
  logic           pr_has_next_angle;
  logic [DW-1:0]  pr0_val;
  logic [DW-1:0]  pr1_val;
  logic [15:0]    stat_stall_cycles;
  logic [15:0]    stat_underrun_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nabp_filtered_ram_ring_control #(
    .NUM_BUFS (NB), .ANGLE_W (AW), .S_W (SW), .DATA_W (DW)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .hs_angle                  (hs_angle),
    .hs_has_next_angle         (hs_has_next_angle),
    .hs_next_angle_ack         (hs_next_angle_ack),
    .hs_next_angle             (hs_next_angle),
    .hs_s_val                  (hs_s_val),
    .buf_hs_s_val              (buf_hs_s_val),
    .buf_fill_kick             (buf_fill_kick),
    .buf_fill_done             (buf_fill_done),
    .buf_pr0_val               (buf_pr0_val),
    .buf_pr1_val               (buf_pr1_val),
    .pr_next_angle             (pr_next_angle),
    .pr_next_angle_ack         (pr_next_angle_ack),
    .pr_prev_angle_release     (pr_prev_angle_release),
    .pr_prev_angle_release_ack (pr_prev_angle_release_ack),
    .pr_angle                  (pr_angle),
    .pr_has_next_angle         (pr_has_next_angle),
    .pr0_val                   (pr0_val),
    .pr1_val                   (pr1_val),
    .stat_stall_cycles         (stat_stall_cycles),
    .stat_underrun_cycles      (stat_underrun_cycles)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset_n               = 1'b0;
    hs_angle              = '0;
    hs_has_next_angle     = 1'b0;
    hs_next_angle_ack     = 1'b0;
    buf_fill_done         = '0;
    pr_next_angle         = 1'b0;
    pr_prev_angle_release = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    settle();
  endtask

  // Host offers an angle, the expected slot is kicked, then reports done.
  task automatic fill(input logic [AW-1:0] ang, input int slot);
    logic [NB-1:0] k;
    k = NB'(1) << slot;
    hs_angle          = ang;
    hs_has_next_angle = 1'b1;
    hs_next_angle_ack = 1'b1;
    tick();
    hs_next_angle_ack = 1'b0;
    settle();
    check_val($sformatf("fill%0d_kick", ang), 32'(buf_fill_kick), 32'(k));
    buf_fill_done = k;
    tick();
    buf_fill_done = '0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    tick();
    settle();
    check_val("rst_hs_next_in_reset", 32'(hs_next_angle), 0);
    do_reset();
    check_val("rst_hs_next", 32'(hs_next_angle), 1);
    check_val("rst_kick", 32'(buf_fill_kick), 0);
    check_val("rst_pr_angle", 32'(pr_angle), 0);
    check_val("rst_pr_has", 32'(pr_has_next_angle), 1);
    check_val("rst_s_val", 32'(hs_s_val), 10);
    pr_next_angle = 1'b1;
    settle();
    check_val("rst_no_grant", 32'(pr_next_angle_ack), 0);
    pr_next_angle = 1'b0;

    // ---- single fill of angle 5 ----
    hs_angle          = 8'd5;
    hs_has_next_angle = 1'b1;
    hs_next_angle_ack = 1'b1;
    tick();
    hs_next_angle_ack = 1'b0;
    settle();
    check_val("t1_kick", 32'(buf_fill_kick), 32'b001);
    check_val("t1_hs_next_fill", 32'(hs_next_angle), 0);
    tick();
    settle();
    check_val("t1_kick_pulse", 32'(buf_fill_kick), 0);
    buf_fill_done = 3'b001;
    tick();
    buf_fill_done = '0;
    settle();
    check_val("t1_pr_angle", 32'(pr_angle), 5);
    check_val("t1_hs_next", 32'(hs_next_angle), 1);
    check_val("t1_s_val", 32'(hs_s_val), 11);

    // ---- fill the whole ring, stall, release, wrap ----
    do_reset();
    fill(8'd1, 0);
    fill(8'd2, 1);
    fill(8'd3, 2);
    check_val("t2_stall_hs_next", 32'(hs_next_angle), 0);
    check_val("t2_pr_angle", 32'(pr_angle), 1);
    pr_next_angle = 1'b1;
    settle();
    check_val("t2_grant_ack", 32'(pr_next_angle_ack), 1);
    tick();
    pr_next_angle = 1'b0;
    settle();
    check_val("t2_pr_angle2", 32'(pr_angle), 2);
    check_val("t2_pr0", 32'(pr0_val), 32'h1000);
    check_val("t2_pr1", 32'(pr1_val), 32'h2000);
    check_val("t2_still_stall", 32'(hs_next_angle), 0);
    pr_prev_angle_release = 1'b1;
    settle();
    check_val("t2_rel_ack", 32'(pr_prev_angle_release_ack), 1);
    tick();
    pr_prev_angle_release = 1'b0;
    settle();
    check_val("t2_req_back", 32'(hs_next_angle), 1);
    check_val("t2_s_val_wrap", 32'(hs_s_val), 10);
    check_val("t2_stat_stall", 32'(stat_stall_cycles), EXP_STALL);
    fill(8'd4, 0);
    check_val("t2_stall_again", 32'(hs_next_angle), 0);

    // ---- two working slots, blocked third grant, release+grant ----
    pr_next_angle = 1'b1;
    settle();
    check_val("t3_grant1", 32'(pr_next_angle_ack), 1);
    tick();
    settle();
    check_val("t3_pr_angle", 32'(pr_angle), 3);
    check_val("t3_grant2", 32'(pr_next_angle_ack), 1);
    tick();
    settle();
    check_val("t3_grant3_blocked", 32'(pr_next_angle_ack), 0);
    check_val("t3_pr0", 32'(pr0_val), 32'h1001);
    check_val("t3_pr1", 32'(pr1_val), 32'h2002);
    pr_prev_angle_release = 1'b1;
    settle();
    check_val("t3_rel_at2", 32'(pr_prev_angle_release_ack), 1);
    check_val("t3_grant_at2", 32'(pr_next_angle_ack), 0);
    tick();
    settle();
    check_val("t3_pr0_adv", 32'(pr0_val), 32'h1002);
    check_val("t3_both_grant", 32'(pr_next_angle_ack), 1);
    check_val("t3_both_rel", 32'(pr_prev_angle_release_ack), 1);
    tick();
    pr_prev_angle_release = 1'b0;
    settle();
    check_val("t3_pr0_new_old", 32'(pr0_val), 32'h1000);
    check_val("t3_pr1_new", 32'(pr1_val), 32'h2000);
    check_val("t3_pr_angle_empty", 32'(pr_angle), 0);
    check_val("t3_no_grant_empty", 32'(pr_next_angle_ack), 0);
    pr_prev_angle_release = 1'b1;
    settle();
    check_val("t3_rel_one_left", 32'(pr_prev_angle_release_ack), 1);
    pr_next_angle         = 1'b0;
    pr_prev_angle_release = 1'b0;

    // ---- end of projection set: drain ----
    do_reset();
    fill(8'd7, 0);
    fill(8'd8, 1);
    hs_has_next_angle = 1'b0;
    hs_next_angle_ack = 1'b1;
    tick();
    hs_next_angle_ack = 1'b0;
    settle();
    check_val("t4_no_kick", 32'(buf_fill_kick), 0);
    check_val("t4_drain_hs_next", 32'(hs_next_angle), 0);
    check_val("t4_has_before", 32'(pr_has_next_angle), 1);
    pr_next_angle = 1'b1;
    tick();
    tick();
    pr_next_angle = 1'b0;
    settle();
    check_val("t4_has_after", 32'(pr_has_next_angle), 0);
    pr_prev_angle_release = 1'b1;
    tick();
    tick();
    pr_prev_angle_release = 1'b0;
    settle();
    check_val("t4_rel_noop", 32'(pr_prev_angle_release_ack), 0);
    check_val("t4_still_drain", 32'(hs_next_angle), 0);
    tick();
    settle();
    check_val("t4_req_again", 32'(hs_next_angle), 1);
    check_val("t4_has_again", 32'(pr_has_next_angle), 1);

    // ---- reset in the middle of a fill ----
    do_reset();
    hs_angle          = 8'd9;
    hs_has_next_angle = 1'b1;
    hs_next_angle_ack = 1'b1;
    tick();
    hs_next_angle_ack = 1'b0;
    settle();
    check_val("t5_kick", 32'(buf_fill_kick), 32'b001);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    settle();
    check_val("t5_kick_cleared", 32'(buf_fill_kick), 0);
    check_val("t5_req", 32'(hs_next_angle), 1);
    buf_fill_done = 3'b001;
    tick();
    buf_fill_done = '0;
    settle();
    check_val("t5_stale_done_angle", 32'(pr_angle), 0);
    check_val("t5_stale_done_req", 32'(hs_next_angle), 1);
    check_val("t5_s_val", 32'(hs_s_val), 10);

    // ---- statistics ----
    do_reset();
    check_val("t6_stall_rst", 32'(stat_stall_cycles), 0);
    check_val("t6_under_rst", 32'(stat_underrun_cycles), 0);
    pr_next_angle = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    pr_next_angle = 1'b0;
    settle();
    check_val("t6_underrun", 32'(stat_underrun_cycles), EXP_UNDERRUN);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_nabp_filtered_ram_ring_control
`default_nettype wire
